// File: rtl/expande_chave.sv
// Iterative AES-128 key expansion: emits round keys 0..10 over a valid/ready port,
// computing each SubWord with one shared S-box over four cycles.
module expande_chave (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inicio,
  input  logic [127:0] chave,
  output logic         ocupado,
  output logic         rk_valido,
  input  logic         rk_pronto,
  output logic [3:0]   rk_rodada,
  output logic [127:0] rk
);

  typedef enum logic [1:0] {OCIOSO, EMITE, CALCULA} estado_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box as x^254 (multiplicative inverse, 0 -> 0) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x7, x14, x15, x30, x31, x62, x63, x126, x127, inv;
    x2   = gmul(x, x);
    x3   = gmul(x2, x);
    x6   = gmul(x3, x3);
    x7   = gmul(x6, x);
    x14  = gmul(x7, x7);
    x15  = gmul(x14, x);
    x30  = gmul(x15, x15);
    x31  = gmul(x30, x);
    x62  = gmul(x31, x31);
    x63  = gmul(x62, x);
    x126 = gmul(x63, x63);
    x127 = gmul(x126, x);
    inv  = gmul(x127, x127);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  estado_t      state_q, state_d;
  logic [127:0] rk_q, rk_d;
  logic [3:0]   rodada_q, rodada_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [31:0]  temp_q, temp_d;

  logic [7:0]   sb_in, sb_out;
  logic [31:0]  t, w0n, w1n, w2n, w3n;

  // Byte cnt of RotWord(w3): rotation means byte 0 comes from w3[23:16]
  always_comb begin
    sb_in = 8'h00;
    case (cnt_q)
      2'd0: sb_in = rk_q[23:16];
      2'd1: sb_in = rk_q[15:8];
      2'd2: sb_in = rk_q[7:0];
      2'd3: sb_in = rk_q[31:24];
      default: sb_in = 8'h00;
    endcase
  end

  assign sb_out = sbox(sb_in);

  always_comb begin
    state_d  = state_q;
    rk_d     = rk_q;
    rodada_d = rodada_q;
    rcon_d   = rcon_q;
    cnt_d    = cnt_q;
    temp_d   = temp_q;
    t   = 32'h0;
    w0n = 32'h0;
    w1n = 32'h0;
    w2n = 32'h0;
    w3n = 32'h0;
    case (state_q)
      OCIOSO: begin
        if (inicio) begin
          rk_d     = chave;
          rodada_d = 4'd0;
          rcon_d   = 8'h01;
          state_d  = EMITE;
        end
      end
      EMITE: begin
        if (rk_pronto) begin
          if (rodada_q == 4'd10) begin
            state_d = OCIOSO;
          end else begin
            state_d = CALCULA;
            cnt_d   = 2'd0;
          end
        end
      end
      CALCULA: begin
        case (cnt_q)
          2'd0: temp_d[31:24] = sb_out;
          2'd1: temp_d[23:16] = sb_out;
          2'd2: temp_d[15:8]  = sb_out;
          default: temp_d[7:0] = sb_out;
        endcase
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          // temp_d already holds the last S-box byte written this cycle
          t   = temp_d ^ {rcon_q, 24'h0};
          w0n = rk_q[127:96] ^ t;
          w1n = rk_q[95:64]  ^ w0n;
          w2n = rk_q[63:32]  ^ w1n;
          w3n = rk_q[31:0]   ^ w2n;
          rk_d     = {w0n, w1n, w2n, w3n};
          rodada_d = rodada_q + 4'd1;
          rcon_d   = xtime(rcon_q);
          state_d  = EMITE;
        end
      end
      default: state_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= OCIOSO;
      rk_q     <= 128'h0;
      rodada_q <= 4'd0;
      rcon_q   <= 8'h01;
      cnt_q    <= 2'd0;
      temp_q   <= 32'h0;
    end else begin
      state_q  <= state_d;
      rk_q     <= rk_d;
      rodada_q <= rodada_d;
      rcon_q   <= rcon_d;
      cnt_q    <= cnt_d;
      temp_q   <= temp_d;
    end
  end

  assign rk        = rk_q;
  assign rk_rodada = rodada_q;
  assign ocupado   = (state_q != OCIOSO);
  assign rk_valido = (state_q == EMITE);

endmodule
